// File: rtl/round_raw_fn_arbiter.sv
// Two-requester round-robin arbiter in front of a shared e8/s24 rounder.
// Registers the rounder result with a valid/ready handshake and keeps per-requester sticky flags.
module round_raw_fn_arbiter #(
  parameter bit DEFAULT_PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [44:0] req0_raw,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [44:0] req1_raw,
  output logic [44:0] rnd_raw,
  input  logic [32:0] rnd_out,
  input  logic [4:0]  rnd_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] out_data,
  output logic [4:0]  out_flags,
  output logic        out_src,
  input  logic        clr0,
  input  logic        clr1,
  output logic [4:0]  fflags0,
  output logic [4:0]  fflags1
);

  logic lastGrant;
  logic canAccept;
  logic anyValid;
  logic grant;
  logic accept;
  logic outFire;

  // Clear takes effect before the handshake's flags are merged in.
  function automatic logic [4:0] nextFlags(input logic [4:0] cur, input logic clr,
                                           input logic hit, input logic [4:0] newFlags);
    logic [4:0] base;
    base = clr ? 5'b0 : cur;
    return hit ? (base | newFlags) : base;
  endfunction

  always_comb begin
    canAccept = !out_valid || out_ready;
    anyValid  = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~lastGrant;
    else                          grant = req1_valid;
    accept     = canAccept & anyValid;
    outFire    = out_valid & out_ready;
    req0_ready = canAccept & (grant == 1'b0);
    req1_ready = canAccept & (grant == 1'b1);
    rnd_raw    = '0;
    if (accept) rnd_raw = grant ? req1_raw : req0_raw;
  end

  // Result register: load on accept, otherwise drop valid once drained.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
      out_src   <= 1'b0;
      lastGrant <= ~DEFAULT_PRIO;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= rnd_out;
      out_flags <= rnd_flags;
      out_src   <= grant;
      lastGrant <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fflags0 <= '0;
      fflags1 <= '0;
    end else begin
      fflags0 <= nextFlags(fflags0, clr0, outFire && (out_src == 1'b0), out_flags);
      fflags1 <= nextFlags(fflags1, clr1, outFire && (out_src == 1'b1), out_flags);
    end
  end

endmodule

// File: tb/tb_round_raw_fn_arbiter.sv
// Directed bench for round_raw_fn_arbiter with a stub rounder on the rnd_* return path.
module tb_round_raw_fn_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [44:0] req0_raw, req1_raw, rnd_raw;
  logic [32:0] rnd_out, out_data, manOut;
  logic [4:0]  rnd_flags, out_flags, manFlags, fflags0, fflags1;
  logic        out_valid, out_ready, out_src, clr0, clr1;
  logic        useModel;
  int          nChecks = 0;
  int          nErrors = 0;

  localparam logic [44:0] RAW_A = 45'h0123456789A;
  localparam logic [44:0] RAW_B = 45'h0FEDCBA9876;
  localparam logic [32:0] X1 = 33'h1000000FF;
  localparam logic [32:0] X2 = 33'h05555AAAA;

  round_raw_fn_arbiter #(.DEFAULT_PRIO(1'b0)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_raw(req0_raw),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_raw(req1_raw),
    .rnd_raw(rnd_raw), .rnd_out(rnd_out), .rnd_flags(rnd_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .out_src(out_src),
    .clr0(clr0), .clr1(clr1), .fflags0(fflags0), .fflags1(fflags1)
  );

  always #5 clock = ~clock;

  function automatic logic [32:0] modelOut(input logic [44:0] raw);
    return raw[35:3] ^ 33'h123456789;
  endfunction

  // Stub rounder: either a fixed transform of rnd_raw or manually driven values.
  always_comb begin
    rnd_out   = useModel ? modelOut(rnd_raw) : manOut;
    rnd_flags = useModel ? 5'b0 : manFlags;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic       expSrc;
    logic [44:0] expRaw;
    reset = 1'b1; req0_valid = 0; req1_valid = 0; req0_raw = RAW_A; req1_raw = RAW_B;
    out_ready = 0; clr0 = 0; clr1 = 0; useModel = 1; manOut = '0; manFlags = '0;
    tick(); tick();
    checkVal("rst_valid", out_valid, 0);
    checkVal("rst_data", out_data, 0);
    checkVal("rst_flags", out_flags, 0);
    checkVal("rst_src", out_src, 0);
    checkVal("rst_ff0", fflags0, 0);
    checkVal("rst_ff1", fflags1, 0);
    reset = 1'b0;

    // Contended start after reset: req0 first, then req1.
    req0_valid = 1; req1_valid = 1; out_ready = 1;
    #1;
    checkVal("prio_r0", req0_ready, 1);
    checkVal("prio_r1", req1_ready, 0);
    checkVal("prio_raw", rnd_raw, RAW_A);
    tick();
    checkVal("prio_v", out_valid, 1);
    checkVal("prio_src0", out_src, 0);
    checkVal("prio_data0", out_data, modelOut(RAW_A));
    checkVal("rr_r0", req0_ready, 0);
    checkVal("rr_r1", req1_ready, 1);
    checkVal("rr_raw", rnd_raw, RAW_B);
    tick();
    checkVal("rr_src1", out_src, 1);
    checkVal("rr_data1", out_data, modelOut(RAW_B));
    req0_valid = 0; req1_valid = 0;
    tick();
    checkVal("drain_v", out_valid, 0);

    // Single requester with manual rounder result.
    useModel = 0; manOut = 33'h080000000; manFlags = 5'b00001; req0_valid = 1;
    #1;
    checkVal("one_r0", req0_ready, 1);
    tick();
    checkVal("one_v", out_valid, 1);
    checkVal("one_data", out_data, 33'h080000000);
    checkVal("one_flags", out_flags, 5'b00001);
    checkVal("one_src", out_src, 0);
    req0_valid = 0;
    tick();
    checkVal("one_drain", out_valid, 0);
    checkVal("one_ff0", fflags0, 5'b00001);

    // Backpressure: result held, nothing granted.
    req1_valid = 1; out_ready = 0; manOut = X1; manFlags = 5'b10000;
    tick();
    checkVal("bp_v", out_valid, 1);
    checkVal("bp_src", out_src, 1);
    checkVal("bp_data", out_data, X1);
    req0_valid = 1; manOut = X2; manFlags = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkVal("bp_r0", req0_ready, 0);
      checkVal("bp_r1", req1_ready, 0);
      checkVal("bp_raw", rnd_raw, 0);
      checkVal("bp_hold", out_data, X1);
      checkVal("bp_holdv", out_valid, 1);
      tick();
    end
    req0_valid = 0; out_ready = 1;
    #1;
    checkVal("bp_rel_r1", req1_ready, 1);
    checkVal("bp_rel_raw", rnd_raw, RAW_B);
    tick();
    checkVal("bp_new_v", out_valid, 1);
    checkVal("bp_new_src", out_src, 1);
    checkVal("bp_new_data", out_data, X2);
    checkVal("bp_new_flags", out_flags, 5'b00100);
    checkVal("bp_ff1", fflags1, 5'b10000);

    // Clear coincident with handshake, then an unrelated clear.
    req1_valid = 0; clr1 = 1;
    tick();
    checkVal("clr_ff1", fflags1, 5'b00100);
    checkVal("clr_ff0", fflags0, 5'b00001);
    checkVal("clr_v", out_valid, 0);
    clr1 = 0; clr0 = 1;
    tick();
    checkVal("clr0_ff0", fflags0, 0);
    checkVal("clr0_ff1", fflags1, 5'b00100);
    clr0 = 0;

    // Back-to-back contention: alternating, no bubbles.
    useModel = 1; req0_valid = 1; req1_valid = 1; expSrc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req0_raw = RAW_A + (45'(i) << 8);
      req1_raw = RAW_B + (45'(i) << 8);
      expRaw = expSrc ? req1_raw : req0_raw;
      #1;
      checkVal("alt_raw", rnd_raw, expRaw);
      tick();
      checkVal("alt_v", out_valid, 1);
      checkVal("alt_src", out_src, expSrc);
      checkVal("alt_data", out_data, modelOut(expRaw));
      expSrc = ~expSrc;
    end

    // Leave pointer at req0, then reset mid-result.
    req1_valid = 0;
    tick();
    checkVal("pre_rst_src", out_src, 0);
    checkVal("pre_rst_v", out_valid, 1);
    req0_valid = 0; out_ready = 0;
    #2 reset = 1'b1;
    #1;
    checkVal("arst_v", out_valid, 0);
    checkVal("arst_data", out_data, 0);
    checkVal("arst_ff1", fflags1, 0);
    tick();
    reset = 1'b0; req0_valid = 1; req1_valid = 1; out_ready = 1;
    #1;
    checkVal("ptr_r0", req0_ready, 1);
    checkVal("ptr_r1", req1_ready, 0);
    tick();
    checkVal("ptr_src", out_src, 0);
    req0_valid = 0; req1_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
